// File: rtl/chipregs_mm_master.sv
// Register-bus initiator for the chipregs MM slave: one command in flight, one MM strobe per
// command, read-return timeout, and a valid/ready response port. All outputs come from flops.
module chipregs_mm_master #(
  parameter int unsigned          pADDR_W  = 10,
  parameter int unsigned          pDATA_W  = 64,
  parameter logic [15:0]          pTIMEOUT = 16'd256,
  parameter bit                   pWR_RSP  = 1'b1,
  parameter logic [pDATA_W-1:0]   pTO_DATA = pDATA_W'(64'hDEAD_BEEF_DEAD_BEEF)
) (
  input  logic                 iCLK_100M,
  input  logic                 iRST_100M_n,
  input  logic                 iCMD_VALID,
  output logic                 oCMD_READY,
  input  logic                 iCMD_WRITE,
  input  logic [pADDR_W-1:0]   iCMD_ADDR,
  input  logic [pDATA_W-1:0]   iCMD_WDATA,
  output logic                 oRSP_VALID,
  input  logic                 iRSP_READY,
  output logic [pDATA_W-1:0]   oRSP_RDATA,
  output logic [1:0]           oRSP_STATUS,
  output logic [pDATA_W-1:0]   oMM_WR_DATA,
  output logic [pADDR_W-1:0]   oMM_ADDRESS,
  output logic                 oMM_WR_EN,
  output logic                 oMM_RD_EN,
  input  logic [pDATA_W-1:0]   iMM_RD_DATA,
  input  logic                 iMM_RD_DATA_V,
  output logic                 oBUSY,
  output logic [15:0]          oTIMEOUT_CNT,
  output logic [7:0]           oSTRAY_CNT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  logic [1:0]           r_state;
  logic                 r_cmdReady;
  logic                 r_cmdWrite;
  logic [pADDR_W-1:0]   r_mmAddr;
  logic [pDATA_W-1:0]   r_mmWrData;
  logic                 r_mmWrEn;
  logic                 r_mmRdEn;
  logic [15:0]          r_waitCnt;
  logic                 r_rspValid;
  logic [pDATA_W-1:0]   r_rspRdata;
  logic [1:0]           r_rspStatus;
  logic [15:0]          r_timeoutCnt;
  logic [7:0]           r_strayCnt;

  // The address/data registers are loaded on acceptance, so they show the command during ISSUE
  // and simply keep that value afterwards; strobes default low and pulse for the ISSUE cycle only.
  always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
    if (!iRST_100M_n) begin
      r_state      <= S_IDLE;
      r_cmdReady   <= 1'b0;
      r_cmdWrite   <= 1'b0;
      r_mmAddr     <= '0;
      r_mmWrData   <= '0;
      r_mmWrEn     <= 1'b0;
      r_mmRdEn     <= 1'b0;
      r_waitCnt    <= '0;
      r_rspValid   <= 1'b0;
      r_rspRdata   <= '0;
      r_rspStatus  <= ST_OK;
      r_timeoutCnt <= '0;
    end else begin
      r_mmWrEn <= 1'b0;
      r_mmRdEn <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmdReady <= 1'b1;
          if (iCMD_VALID && r_cmdReady) begin
            r_cmdReady <= 1'b0;
            r_cmdWrite <= iCMD_WRITE;
            r_mmAddr   <= iCMD_ADDR;
            r_mmWrData <= iCMD_WDATA;
            r_mmWrEn   <= iCMD_WRITE;
            r_mmRdEn   <= !iCMD_WRITE;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_waitCnt <= '0;
          if (!r_cmdWrite) begin
            r_state <= S_WAIT_RD;
          end else if (pWR_RSP) begin
            r_rspValid  <= 1'b1;
            r_rspRdata  <= '0;
            r_rspStatus <= ST_OK;
            r_state     <= S_RESP;
          end else begin
            r_cmdReady <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        S_WAIT_RD: begin
          r_waitCnt <= r_waitCnt + 16'd1;
          // Data arriving in the final counted cycle still beats the timeout.
          if (iMM_RD_DATA_V) begin
            r_rspValid  <= 1'b1;
            r_rspRdata  <= iMM_RD_DATA;
            r_rspStatus <= ST_OK;
            r_state     <= S_RESP;
          end else if (r_waitCnt == pTIMEOUT - 16'd1) begin
            r_rspValid  <= 1'b1;
            r_rspRdata  <= pTO_DATA;
            r_rspStatus <= ST_TIMEOUT;
            if (r_timeoutCnt != 16'hFFFF) begin
              r_timeoutCnt <= r_timeoutCnt + 16'd1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (iRSP_READY) begin
            r_rspValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Any return strobe the FSM is not waiting for is discarded but counted.
  always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
    if (!iRST_100M_n) begin
      r_strayCnt <= '0;
    end else if (iMM_RD_DATA_V && (r_state != S_WAIT_RD) && (r_strayCnt != 8'hFF)) begin
      r_strayCnt <= r_strayCnt + 8'd1;
    end
  end

  always_ff @(posedge iCLK_100M) begin
    if (iRST_100M_n) begin
      assert (pTIMEOUT != 16'd0) else $error("chipregs_mm_master: pTIMEOUT must be nonzero");
    end
  end

  assign oCMD_READY   = r_cmdReady;
  assign oRSP_VALID   = r_rspValid;
  assign oRSP_RDATA   = r_rspRdata;
  assign oRSP_STATUS  = r_rspStatus;
  assign oMM_WR_DATA  = r_mmWrData;
  assign oMM_ADDRESS  = r_mmAddr;
  assign oMM_WR_EN    = r_mmWrEn;
  assign oMM_RD_EN    = r_mmRdEn;
  assign oBUSY        = (r_state != S_IDLE);
  assign oTIMEOUT_CNT = r_timeoutCnt;
  assign oSTRAY_CNT   = r_strayCnt;

endmodule

// File: tb/tb_chipregs_mm_master.sv
// Scoreboard bench for chipregs_mm_master: a driver queues expected strobes and responses from a
// latency-based model of the slave, and independent monitors pop and compare them.
module tb_chipregs_mm_master;

  localparam int          T       = 8;
  localparam logic [63:0] TO_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int          SILENT  = -1;

  typedef struct { bit write; logic [9:0] addr; logic [63:0] wdata; int acc; } cmd_t;
  typedef struct { logic [63:0] rdata; logic [1:0] status; int cyc; } rsp_t;
  typedef struct { int lat; logic [63:0] data; } slv_t;

  logic        iCLK_100M = 1'b0;
  logic        iRST_100M_n = 1'b0;
  logic        iCMD_VALID = 1'b0;
  logic        oCMD_READY;
  logic        iCMD_WRITE = 1'b0;
  logic [9:0]  iCMD_ADDR = '0;
  logic [63:0] iCMD_WDATA = '0;
  logic        oRSP_VALID;
  logic        iRSP_READY;
  logic [63:0] oRSP_RDATA;
  logic [1:0]  oRSP_STATUS;
  logic [63:0] oMM_WR_DATA;
  logic [9:0]  oMM_ADDRESS;
  logic        oMM_WR_EN;
  logic        oMM_RD_EN;
  logic [63:0] iMM_RD_DATA;
  logic        iMM_RD_DATA_V;
  logic        oBUSY;
  logic [15:0] oTIMEOUT_CNT;
  logic [7:0]  oSTRAY_CNT;

  cmd_t cmdQ[$];
  rsp_t rspQ[$];
  slv_t slaveQ[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int expTimeouts = 0;
  int expStray = 0;
  int holdTag = 0;
  int holdServed = 0;
  int holdLeft = 0;
  int strayReqN = 0;
  int strayAckN = 0;
  bit fastRsp = 1'b0;
  bit rspSeen = 1'b0;
  bit hsPrev = 1'b0;
  logic [63:0] heldData;
  logic [1:0]  heldStat;
  rsp_t monRsp;
  cmd_t monCmd;
  slv_t slvCur;
  bit   rndWrite;
  int   rndLat;
  int   rndSel;

  chipregs_mm_master #(
    .pADDR_W (10),
    .pDATA_W (64),
    .pTIMEOUT(16'd8),
    .pWR_RSP (1'b1),
    .pTO_DATA(TO_DATA)
  ) dut (
    .iCLK_100M    (iCLK_100M),
    .iRST_100M_n  (iRST_100M_n),
    .iCMD_VALID   (iCMD_VALID),
    .oCMD_READY   (oCMD_READY),
    .iCMD_WRITE   (iCMD_WRITE),
    .iCMD_ADDR    (iCMD_ADDR),
    .iCMD_WDATA   (iCMD_WDATA),
    .oRSP_VALID   (oRSP_VALID),
    .iRSP_READY   (iRSP_READY),
    .oRSP_RDATA   (oRSP_RDATA),
    .oRSP_STATUS  (oRSP_STATUS),
    .oMM_WR_DATA  (oMM_WR_DATA),
    .oMM_ADDRESS  (oMM_ADDRESS),
    .oMM_WR_EN    (oMM_WR_EN),
    .oMM_RD_EN    (oMM_RD_EN),
    .iMM_RD_DATA  (iMM_RD_DATA),
    .iMM_RD_DATA_V(iMM_RD_DATA_V),
    .oBUSY        (oBUSY),
    .oTIMEOUT_CNT (oTIMEOUT_CNT),
    .oSTRAY_CNT   (oSTRAY_CNT)
  );

  always #5 iCLK_100M = ~iCLK_100M;
  always @(posedge iCLK_100M) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
  endtask

  // A read returns slave data only if the return strobe lands inside the WAIT_RD window,
  // i.e. 1..T cycles after the MM strobe; anything else times out, and a strobe that lands
  // just outside that window (in ISSUE or right after the timeout) is a stray.
  task automatic applyStimulus(input bit write, input logic [9:0] addr, input logic [63:0] wdata,
                               input int lat, input logic [63:0] rdata);
    int waited;
    cmd_t c;
    rsp_t r;
    slv_t s;
    waited = 0;
    iCMD_VALID = 1'b1;
    iCMD_WRITE = write;
    iCMD_ADDR  = addr;
    iCMD_WDATA = wdata;
    while (!oCMD_READY && waited < 1000) begin
      @(negedge iCLK_100M);
      waited++;
    end
    if (!oCMD_READY) begin
      failNow("cmd_accept_timeout");
      iCMD_VALID = 1'b0;
      return;
    end
    c = '{write, addr, wdata, cyc};
    cmdQ.push_back(c);
    if (write) begin
      r = '{64'd0, 2'b00, cyc + 2};
    end else begin
      s = '{lat, rdata};
      slaveQ.push_back(s);
      if (lat >= 1 && lat <= T) begin
        r = '{rdata, 2'b00, cyc + 2 + lat};
      end else begin
        r = '{TO_DATA, 2'b01, cyc + 2 + T};
        if (expTimeouts < 65535) expTimeouts++;
        if ((lat == 0 || lat == T + 1) && expStray < 255) expStray++;
      end
    end
    rspQ.push_back(r);
    @(negedge iCLK_100M);
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while ((rspQ.size() != 0 || cmdQ.size() != 0 || oBUSY || oRSP_VALID) && k < 2000) begin
      @(negedge iCLK_100M);
      k++;
    end
    if (k >= 2000) failNow("drain_timeout");
    repeat (2) @(negedge iCLK_100M);
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_cmd_ready"}, oCMD_READY, 0);
    checkOutput({pfx, "_rsp_valid"}, oRSP_VALID, 0);
    checkOutput({pfx, "_rsp_rdata"}, oRSP_RDATA, 0);
    checkOutput({pfx, "_rsp_status"}, oRSP_STATUS, 0);
    checkOutput({pfx, "_mm_wr_en"}, oMM_WR_EN, 0);
    checkOutput({pfx, "_mm_rd_en"}, oMM_RD_EN, 0);
    checkOutput({pfx, "_mm_addr"}, oMM_ADDRESS, 0);
    checkOutput({pfx, "_mm_wdata"}, oMM_WR_DATA, 0);
    checkOutput({pfx, "_busy"}, oBUSY, 0);
    checkOutput({pfx, "_timeout_cnt"}, oTIMEOUT_CNT, 0);
    checkOutput({pfx, "_stray_cnt"}, oSTRAY_CNT, 0);
  endtask

  // Slave model: answers each read strobe after its queued latency, or never when silent.
  initial begin
    iMM_RD_DATA_V = 1'b0;
    iMM_RD_DATA   = {$urandom, $urandom};
    forever begin
      @(negedge iCLK_100M);
      if (iRST_100M_n && oMM_RD_EN && slaveQ.size() > 0) begin
        slvCur = slaveQ.pop_front();
        if (slvCur.lat >= 0) begin
          repeat (slvCur.lat) @(negedge iCLK_100M);
          iMM_RD_DATA_V = 1'b1;
          iMM_RD_DATA   = slvCur.data;
          @(negedge iCLK_100M);
          iMM_RD_DATA_V = 1'b0;
          iMM_RD_DATA   = {$urandom, $urandom};
        end
      end else if (strayReqN != strayAckN) begin
        strayAckN++;
        iMM_RD_DATA_V = 1'b1;
        iMM_RD_DATA   = {$urandom, $urandom};
        @(negedge iCLK_100M);
        iMM_RD_DATA_V = 1'b0;
      end
    end
  end

  // Strobe monitor: every MM strobe must match the oldest accepted command, one cycle later.
  initial begin
    forever begin
      @(negedge iCLK_100M);
      if (iRST_100M_n && (oMM_WR_EN || oMM_RD_EN)) begin
        checkOutput("strobe_exclusive", 64'(oMM_WR_EN & oMM_RD_EN), 0);
        if (cmdQ.size() == 0) begin
          failNow("strobe_unexpected");
        end else begin
          monCmd = cmdQ.pop_front();
          checkOutput("strobe_kind", 64'(oMM_WR_EN), 64'(monCmd.write));
          checkOutput("strobe_addr", 64'(oMM_ADDRESS), 64'(monCmd.addr));
          checkOutput("strobe_wdata", oMM_WR_DATA, monCmd.wdata);
          checkOutput("strobe_cycle", 64'(cyc), 64'(monCmd.acc + 1));
          checkOutput("strobe_busy", 64'(oBUSY), 1);
        end
      end
    end
  end

  // Response monitor: owns iRSP_READY, checks each new beat against the scoreboard and
  // checks that a stalled beat stays put.
  initial begin
    iRSP_READY = 1'b0;
    forever begin
      @(negedge iCLK_100M);
      if (!iRST_100M_n) begin
        rspSeen = 1'b0;
        hsPrev = 1'b0;
        holdLeft = 0;
        iRSP_READY = 1'b0;
      end else begin
        if (hsPrev) begin
          checkOutput("rsp_valid_drop", 64'(oRSP_VALID), 0);
          checkOutput("ready_after_rsp", 64'(oCMD_READY), 1);
          rspSeen = 1'b0;
          hsPrev = 1'b0;
        end
        if (oRSP_VALID) begin
          if (!rspSeen) begin
            if (rspQ.size() == 0) begin
              failNow("rsp_unexpected");
            end else begin
              monRsp = rspQ.pop_front();
              checkOutput("rsp_rdata", oRSP_RDATA, monRsp.rdata);
              checkOutput("rsp_status", 64'(oRSP_STATUS), 64'(monRsp.status));
              checkOutput("rsp_latency", 64'(cyc), 64'(monRsp.cyc));
            end
            heldData = oRSP_RDATA;
            heldStat = oRSP_STATUS;
            rspSeen = 1'b1;
            if (holdTag != holdServed) begin
              holdServed = holdTag;
              holdLeft = 5;
            end
          end else begin
            checkOutput("rsp_rdata_stable", oRSP_RDATA, heldData);
            checkOutput("rsp_status_stable", 64'(oRSP_STATUS), 64'(heldStat));
            checkOutput("cmd_ready_stalled", 64'(oCMD_READY), 0);
          end
          if (holdLeft > 0) begin
            iRSP_READY = 1'b0;
            holdLeft--;
          end else begin
            iRSP_READY = fastRsp ? 1'b1 : ($urandom_range(0, 2) != 0);
          end
          hsPrev = iRSP_READY;
        end else begin
          iRSP_READY = ($urandom_range(0, 1) != 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRST_100M_n = 1'b0;
    repeat (3) @(negedge iCLK_100M);
    checkResetOutputs("reset");
    iRST_100M_n = 1'b1;
    @(negedge iCLK_100M);
    checkOutput("ready_after_reset", 64'(oCMD_READY), 1);

    applyStimulus(1'b1, 10'd17, 64'h5F5E100, 0, 64'd0);
    iCMD_VALID = 1'b0;
    waitDrain();
    applyStimulus(1'b0, 10'd3, {$urandom, $urandom}, 2, 64'h0123_4567_89AB_CDEF);
    iCMD_VALID = 1'b0;
    waitDrain();

    $display("[TB] silent read, timeout then late strobe");
    checkOutput("timeout_cnt_before", 64'(oTIMEOUT_CNT), 0);
    applyStimulus(1'b0, 10'd100, {$urandom, $urandom}, SILENT, 64'd0);
    iCMD_VALID = 1'b0;
    waitDrain();
    checkOutput("timeout_cnt_after", 64'(oTIMEOUT_CNT), 64'(expTimeouts));
    strayReqN++;
    expStray++;
    repeat (4) @(negedge iCLK_100M);
    checkOutput("stray_cnt_late", 64'(oSTRAY_CNT), 64'(expStray));

    $display("[TB] response held off for 5 cycles");
    holdTag++;
    applyStimulus(1'b0, 10'd511, {$urandom, $urandom}, 3, {$urandom, $urandom});
    iCMD_VALID = 1'b0;
    waitDrain();

    $display("[TB] four back-to-back commands");
    fastRsp = 1'b1;
    applyStimulus(1'b1, 10'd1, {$urandom, $urandom}, 0, 64'd0);
    applyStimulus(1'b0, 10'd2, {$urandom, $urandom}, 1, {$urandom, $urandom});
    applyStimulus(1'b1, 10'd3, {$urandom, $urandom}, 0, 64'd0);
    applyStimulus(1'b0, 10'd4, {$urandom, $urandom}, 2, {$urandom, $urandom});
    iCMD_VALID = 1'b0;
    waitDrain();
    fastRsp = 1'b0;

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      rndWrite = ($urandom_range(0, 1) != 0);
      rndSel = $urandom_range(0, 9);
      case (rndSel)
        0: rndLat = SILENT;
        1: rndLat = 0;
        2: rndLat = T + 1;
        3: rndLat = T;
        default: rndLat = $urandom_range(1, T);
      endcase
      applyStimulus(rndWrite, 10'($urandom_range(0, 1023)), {$urandom, $urandom}, rndLat,
                    {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        iCMD_VALID = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge iCLK_100M);
      end
    end
    iCMD_VALID = 1'b0;
    waitDrain();
    checkOutput("timeout_cnt_random", 64'(oTIMEOUT_CNT), 64'(expTimeouts));
    checkOutput("stray_cnt_random", 64'(oSTRAY_CNT), 64'(expStray));

    $display("[TB] reset during WAIT_RD");
    applyStimulus(1'b0, 10'd55, {$urandom, $urandom}, SILENT, 64'd0);
    iCMD_VALID = 1'b0;
    repeat (3) @(negedge iCLK_100M);
    iRST_100M_n = 1'b0;
    rspQ.delete();
    expTimeouts = 0;
    expStray = 0;
    repeat (2) @(negedge iCLK_100M);
    checkResetOutputs("midrst");
    iRST_100M_n = 1'b1;
    @(negedge iCLK_100M);
    checkOutput("ready_after_midrst", 64'(oCMD_READY), 1);
    strayReqN++;
    expStray++;
    repeat (4) @(negedge iCLK_100M);
    checkOutput("stray_cnt_midrst", 64'(oSTRAY_CNT), 64'(expStray));
    checkOutput("timeout_cnt_midrst", 64'(oTIMEOUT_CNT), 64'(expTimeouts));
    checkOutput("rsp_valid_midrst", 64'(oRSP_VALID), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
